// File: rtl/score_keeper.sv
// score_keeper: rhythm-game scoring block.
// Turns per-lane hit/miss levels into accepted events, keeps a BCD score,
// a consecutive-hit combo and a lives count, and runs the IDLE/PLAY/OVER
// game state machine. Each hit lane has its own re-trigger lockout.
module score_keeper #(
    parameter int LANES      = 4,
    parameter int LIVES_INIT = 3,
    parameter int HOLDOFF    = 3000,
    parameter int COMBO_X2   = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [LANES-1:0] hit,
    input  logic [LANES-1:0] miss,
    output logic [11:0]      score_bcd,
    output logic [7:0]       combo,
    output logic [3:0]       lives,
    output logic             playing,
    output logic             game_over,
    output logic             hit_pulse,
    output logic             miss_pulse
);

    localparam int CNT_W  = $clog2(LANES + 1);
    localparam int PTS_W  = CNT_W + 1;
    localparam int LOCK_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t            state;

    // Registered copies of the lane inputs, used for rising-edge detection
    logic [LANES-1:0]  hit_p0;
    logic [LANES-1:0]  miss_p0;

    // Per-lane lockout counters; a lane accepts a new hit only at zero
    logic [LOCK_W-1:0] lock_cnt [LANES];

    logic [LANES-1:0]  hit_acc;
    logic [LANES-1:0]  miss_acc;
    logic [CNT_W-1:0]  n_hits;
    logic [CNT_W-1:0]  n_miss;
    logic [PTS_W-1:0]  points;
    logic [11:0]       score_nx;
    logic [7:0]        combo_nx;
    logic [3:0]        lives_nx;

    // Number of set bits in a lane vector
    function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Add a small binary value to a three-digit BCD number, clamping at 999.
    // The BCD value is folded to binary, summed, clamped and re-encoded with
    // a shift-add-3 conversion so every digit stays in 0-9.
    function automatic logic [11:0] bcd_add_sat(input logic [11:0]      bcd,
                                                input logic [PTS_W-1:0] pts);
        logic [15:0] bin;
        logic [21:0] sh;
        bin = 16'(bcd[11:8]) * 16'd100
            + 16'(bcd[7:4])  * 16'd10
            + 16'(bcd[3:0])
            + 16'(pts);
        if (bin > 16'd999) begin
            bin = 16'd999;
        end
        sh = {12'd0, bin[9:0]};
        for (int k = 0; k < 10; k++) begin
            if (sh[13:10] >= 4'd5) sh[13:10] = sh[13:10] + 4'd3;
            if (sh[17:14] >= 4'd5) sh[17:14] = sh[17:14] + 4'd3;
            if (sh[21:18] >= 4'd5) sh[21:18] = sh[21:18] + 4'd3;
            sh = sh << 1;
        end
        return sh[21:10];
    endfunction

    // Combo increment that sticks at 255
    function automatic logic [7:0] combo_add_sat(input logic [7:0]       c,
                                                 input logic [CNT_W-1:0] n);
        logic [15:0] s;
        s = 16'(c) + 16'(n);
        if (s > 16'd255) begin
            return 8'hFF;
        end
        return s[7:0];
    endfunction

    // Lives decrement that stops at zero
    function automatic logic [3:0] lives_sub_floor(input logic [3:0]       l,
                                                   input logic [CNT_W-1:0] m);
        if (16'(m) >= 16'(l)) begin
            return 4'd0;
        end
        return l - 4'(m);
    endfunction

    // Accept edges, count them and precompute next score/combo/lives
    always_comb begin
        hit_acc  = '0;
        miss_acc = '0;
        for (int i = 0; i < LANES; i++) begin
            if (state == PLAY) begin
                hit_acc[i]  = hit[i] & ~hit_p0[i] & (lock_cnt[i] == '0);
                miss_acc[i] = miss[i] & ~miss_p0[i];
            end
        end
        n_hits   = popcount(hit_acc);
        n_miss   = popcount(miss_acc);
        // Multiplier is chosen from the combo value before this cycle's update
        points   = (int'(combo) >= COMBO_X2) ? {n_hits, 1'b0} : {1'b0, n_hits};
        score_nx = bcd_add_sat(score_bcd, points);
        // Any miss breaks the combo, even if hits landed in the same cycle
        combo_nx = (n_miss != '0) ? 8'd0 : combo_add_sat(combo, n_hits);
        lives_nx = lives_sub_floor(lives, n_miss);
    end

    // Register the raw lane inputs every cycle, in every state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_p0  <= '0;
            miss_p0 <= '0;
        end else begin
            hit_p0  <= hit;
            miss_p0 <= miss;
        end
    end

    // Lockout counters: load on an accepted hit, otherwise count down to zero
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (!resetn) begin
                lock_cnt[i] <= '0;
            end else if (hit_acc[i]) begin
                lock_cnt[i] <= LOCK_W'(HOLDOFF);
            end else if (lock_cnt[i] != '0) begin
                lock_cnt[i] <= lock_cnt[i] - LOCK_W'(1);
            end
        end
    end

    // Game state machine with registered score, combo, lives, flags and strobes
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            score_bcd  <= 12'h000;
            combo      <= 8'd0;
            lives      <= 4'd0;
            playing    <= 1'b0;
            game_over  <= 1'b0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            unique case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state     <= PLAY;
                        score_bcd <= 12'h000;
                        combo     <= 8'd0;
                        lives     <= 4'(LIVES_INIT);
                        playing   <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                PLAY: begin
                    score_bcd  <= score_nx;
                    combo      <= combo_nx;
                    lives      <= lives_nx;
                    hit_pulse  <= (n_hits != '0);
                    miss_pulse <= (n_miss != '0);
                    if (lives_nx == 4'd0) begin
                        state     <= OVER;
                        playing   <= 1'b0;
                        game_over <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    playing   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: two instances (full lockout and a short lockout for
// reaching the score ceiling) share the same stimulus. A behavioural game
// model per instance is compared against the outputs every cycle, and
// directed sequences carry hand-computed literal expectations.
module tb_score_keeper;

    localparam int NL        = 4;
    localparam int HOLD_SLOW = 3000;
    localparam int HOLD_FAST = 2;

    logic          clk;
    logic          resetn;
    logic          start;
    logic [NL-1:0] hit;
    logic [NL-1:0] miss;

    logic [11:0]   d_score [2];
    logic [7:0]    d_combo [2];
    logic [3:0]    d_lives [2];
    logic          d_play  [2];
    logic          d_over  [2];
    logic          d_hp    [2];
    logic          d_mp    [2];

    int vectors     = 0;
    int miscompares = 0;

    score_keeper #(.LANES(NL), .LIVES_INIT(3), .HOLDOFF(HOLD_SLOW), .COMBO_X2(8)) u_slow (
        .clk(clk), .resetn(resetn), .start(start), .hit(hit), .miss(miss),
        .score_bcd(d_score[0]), .combo(d_combo[0]), .lives(d_lives[0]),
        .playing(d_play[0]), .game_over(d_over[0]),
        .hit_pulse(d_hp[0]), .miss_pulse(d_mp[0])
    );

    score_keeper #(.LANES(NL), .LIVES_INIT(3), .HOLDOFF(HOLD_FAST), .COMBO_X2(8)) u_fast (
        .clk(clk), .resetn(resetn), .start(start), .hit(hit), .miss(miss),
        .score_bcd(d_score[1]), .combo(d_combo[1]), .lives(d_lives[1]),
        .playing(d_play[1]), .game_over(d_over[1]),
        .hit_pulse(d_hp[1]), .miss_pulse(d_mp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int s);
        return 12'(((s / 100) << 8) | (((s / 10) % 10) << 4) | (s % 10));
    endfunction

    // ---------------- behavioural game model ----------------
    int      m_score [2];
    int      m_combo [2];
    int      m_lives [2];
    bit      m_play  [2];
    bit      m_over  [2];
    bit      m_hp    [2];
    bit      m_mp    [2];
    longint  m_ready [2][NL];   // first cycle at which a lane may score again
    longint  cyc = 0;
    bit [NL-1:0] ph = '0;
    bit [NL-1:0] pm = '0;
    bit      model_on = 1'b0;

    task automatic model_step(input int k, input int hold);
        int n;
        int m;
        int pts;
        if (!resetn) begin
            m_score[k] = 0; m_combo[k] = 0; m_lives[k] = 0;
            m_play[k]  = 0; m_over[k]  = 0; m_hp[k] = 0; m_mp[k] = 0;
            for (int i = 0; i < NL; i++) m_ready[k][i] = 0;
        end else begin
            m_hp[k] = 0;
            m_mp[k] = 0;
            if (m_play[k]) begin
                n = 0;
                m = 0;
                for (int i = 0; i < NL; i++) begin
                    if (hit[i] && !ph[i] && cyc >= m_ready[k][i]) begin
                        n++;
                        m_ready[k][i] = cyc + hold + 1;
                    end
                    if (miss[i] && !pm[i]) m++;
                end
                pts = (m_combo[k] >= 8) ? 2 * n : n;
                m_score[k] = (m_score[k] + pts > 999) ? 999 : m_score[k] + pts;
                if (m > 0) m_combo[k] = 0;
                else m_combo[k] = (m_combo[k] + n > 255) ? 255 : m_combo[k] + n;
                m_lives[k] = (m_lives[k] > m) ? m_lives[k] - m : 0;
                m_hp[k] = (n > 0);
                m_mp[k] = (m > 0);
                if (m_lives[k] == 0) begin
                    m_play[k] = 0;
                    m_over[k] = 1;
                end
            end else if (start) begin
                m_play[k]  = 1; m_over[k] = 0;
                m_score[k] = 0; m_combo[k] = 0; m_lives[k] = 3;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, HOLD_SLOW);
        model_step(1, HOLD_FAST);
        if (!resetn) begin
            ph = '0;
            pm = '0;
            model_on = 1'b1;
        end else begin
            ph = hit;
            pm = miss;
        end
        cyc++;
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (model_on) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model score[%0d] cyc %0d", k, cyc), d_score[k], to_bcd(m_score[k]));
                chk($sformatf("model combo[%0d] cyc %0d", k, cyc), d_combo[k], m_combo[k]);
                chk($sformatf("model lives[%0d] cyc %0d", k, cyc), d_lives[k], m_lives[k]);
                chk($sformatf("model playing[%0d] cyc %0d", k, cyc), d_play[k], m_play[k]);
                chk($sformatf("model game_over[%0d] cyc %0d", k, cyc), d_over[k], m_over[k]);
                chk($sformatf("model hit_pulse[%0d] cyc %0d", k, cyc), d_hp[k], m_hp[k]);
                chk($sformatf("model miss_pulse[%0d] cyc %0d", k, cyc), d_mp[k], m_mp[k]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_hit(input logic [NL-1:0] mask);
        hit = mask;
        cycles(1);
        hit = '0;
    endtask

    task automatic reset_and_start();
        resetn = 1'b0;
        cycles(2);
        resetn = 1'b1;
        start  = 1'b1;
        cycles(1);
        start  = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        hit    = '0;
        miss   = '0;
        cycles(3);
        chk("reset score", d_score[0], 12'h000);
        chk("reset combo", d_combo[0], 0);
        chk("reset lives", d_lives[0], 0);
        chk("reset playing", d_play[0], 0);
        chk("reset game_over", d_over[0], 0);
        chk("reset hit_pulse", d_hp[0], 0);
        resetn = 1'b1;
        cycles(2);
        chk("idle playing", d_play[0], 0);

        // First game: one hit on lane 0
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        chk("start playing", d_play[0], 1);
        chk("start lives", d_lives[0], 3);
        hit = 4'b0001;
        cycles(1);
        chk("first hit score", d_score[0], 12'h001);
        chk("first hit combo", d_combo[0], 1);
        chk("first hit lives", d_lives[0], 3);
        chk("first hit pulse", d_hp[0], 1);
        cycles(1);
        chk("first hit pulse drop", d_hp[0], 0);

        // Lane 0 toggled every 10 cycles inside the lockout window
        cycles(8);
        hit[0] = 1'b0;
        for (int j = 1; j < 300; j++) begin
            cycles(10);
            hit[0] = ~hit[0];
        end
        cycles(1);
        chk("lockout score", d_score[0], 12'h001);
        chk("lockout combo", d_combo[0], 1);
        cycles(9);
        hit[0] = 1'b0;
        cycles(10);
        hit[0] = 1'b1;
        cycles(1);
        chk("after lockout score", d_score[0], 12'h002);
        chk("after lockout combo", d_combo[0], 2);
        chk("after lockout pulse", d_hp[0], 1);
        hit = '0;

        // Combo crosses the doubling threshold
        reset_and_start();
        pulse_hit(4'b1111);
        chk("combo4 score", d_score[0], 12'h004);
        chk("combo4 combo", d_combo[0], 4);
        cycles(3005);
        pulse_hit(4'b0111);
        chk("combo7 score", d_score[0], 12'h007);
        chk("combo7 combo", d_combo[0], 7);
        cycles(3005);
        pulse_hit(4'b0011);
        chk("combo9 score", d_score[0], 12'h009);
        chk("combo9 combo", d_combo[0], 9);
        cycles(2);
        pulse_hit(4'b0100);
        chk("double score", d_score[0], 12'h011);
        chk("double combo", d_combo[0], 10);

        // Score ceiling on the short-lockout instance
        reset_and_start();
        for (int j = 0; j < 2; j++) begin
            pulse_hit(4'b1111);
            cycles(2);
        end
        chk("fast score8", d_score[1], 12'h008);
        chk("fast combo8", d_combo[1], 8);
        for (int j = 0; j < 123; j++) begin
            pulse_hit(4'b1111);
            cycles(2);
        end
        chk("fast score992", d_score[1], 12'h992);
        chk("fast combo sat", d_combo[1], 255);
        pulse_hit(4'b0111);
        chk("fast score998", d_score[1], 12'h998);
        cycles(2);
        pulse_hit(4'b0011);
        chk("fast score sat", d_score[1], 12'h999);
        chk("fast combo still sat", d_combo[1], 255);
        cycles(2);
        pulse_hit(4'b0001);
        chk("fast score stays sat", d_score[1], 12'h999);
        chk("fast sat hit pulse", d_hp[1], 1);

        // Lives run out with a simultaneous hit and miss
        reset_and_start();
        miss = 4'b0001;
        cycles(1);
        miss = '0;
        chk("miss1 lives", d_lives[0], 2);
        chk("miss1 pulse", d_mp[0], 1);
        cycles(1);
        miss = 4'b0010;
        cycles(1);
        miss = '0;
        chk("miss2 lives", d_lives[0], 1);
        cycles(1);
        hit  = 4'b0100;
        miss = 4'b1000;
        cycles(1);
        hit  = '0;
        miss = '0;
        chk("last score", d_score[0], 12'h001);
        chk("last combo", d_combo[0], 0);
        chk("last lives", d_lives[0], 0);
        chk("last game_over", d_over[0], 1);
        chk("last playing", d_play[0], 0);
        chk("last hit pulse", d_hp[0], 1);
        chk("last miss pulse", d_mp[0], 1);
        cycles(2);
        hit = 4'b0001;
        cycles(1);
        hit = '0;
        chk("over hit score", d_score[0], 12'h001);
        chk("over hit pulse", d_hp[0], 0);
        chk("over still over", d_over[0], 1);
        miss = 4'b0001;
        cycles(1);
        miss = '0;
        chk("over miss lives", d_lives[0], 0);
        chk("over miss pulse", d_mp[0], 0);

        // Restart from OVER with a hit rising in the start cycle
        hit   = 4'b0010;
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        chk("restart playing", d_play[0], 1);
        chk("restart game_over", d_over[0], 0);
        chk("restart score", d_score[0], 12'h000);
        chk("restart combo", d_combo[0], 0);
        chk("restart lives", d_lives[0], 3);
        cycles(5);
        chk("held hit score", d_score[0], 12'h000);
        chk("held hit pulse", d_hp[0], 0);
        hit = '0;

        // Reset in the middle of a game discards the pending hit
        cycles(1);
        hit    = 4'b0001;
        resetn = 1'b0;
        cycles(1);
        chk("midreset score", d_score[0], 12'h000);
        chk("midreset combo", d_combo[0], 0);
        chk("midreset lives", d_lives[0], 0);
        chk("midreset playing", d_play[0], 0);
        chk("midreset hit pulse", d_hp[0], 0);
        resetn = 1'b1;
        cycles(3);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        hit   = '0;
        chk("post reset start score", d_score[0], 12'h000);
        chk("post reset start lives", d_lives[0], 3);

        // start held during PLAY does not reload the game
        cycles(1);
        hit   = 4'b0001;
        start = 1'b1;
        cycles(1);
        chk("play start score", d_score[0], 12'h001);
        chk("play start combo", d_combo[0], 1);
        chk("play start lives", d_lives[0], 3);
        cycles(1);
        start = 1'b0;
        hit   = '0;
        chk("play start kept score", d_score[0], 12'h001);
        chk("play start still playing", d_play[0], 1);

        cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter LANES, default 4: number of note lanes feeding the block.
REQ-002 Parameter LIVES_INIT, default 3: lives loaded at game start, range 1-15.
REQ-003 Parameter HOLDOFF, default 3000: per-lane re-trigger lockout in clk cycles after an accepted hit.
REQ-004 Parameter COMBO_X2, default 8: combo value at or above which a hit scores 2 points.
REQ-005 clk  in  1  system clock (50 MHz); all state changes on posedge clk.
REQ-006 resetn  in  1  reset; synchronous, active-low.
REQ-007 start  in  1  level; begins or restarts a game.
REQ-008 hit  in  LANES  level per lane; lane drawer asserts while a note is in the hit window and the key is held.
REQ-009 miss  in  LANES  level per lane; lane drawer asserts when a note leaves the screen unhit.
REQ-010 score_bcd  out  12  three BCD digits: [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-011 combo  out  8  consecutive-hit count.
REQ-012 lives  out  4  remaining lives.
REQ-013 playing  out  1  high in PLAY state.
REQ-014 game_over  out  1  high in OVER state.
REQ-015 hit_pulse  out  1  one-cycle strobe, at least one hit accepted.
REQ-016 miss_pulse  out  1  one-cycle strobe, at least one miss accepted.

Function
REQ-017 The block SHALL register hit and miss every cycle in all states; edge = input high AND registered copy low.
REQ-018 A hit edge on lane i SHALL be accepted only in PLAY with lane i's lockout counter at 0.
REQ-019 An accepted hit SHALL load lane i's lockout counter with HOLDOFF; the counter decrements by 1 per cycle to 0 in every state.
REQ-020 A miss edge SHALL be accepted only in PLAY; no lockout applies to misses.
REQ-021 State machine: IDLE, PLAY, OVER; IDLE after reset.
REQ-022 IDLE: start=1 -> PLAY next cycle, loading score 0, combo 0, lives LIVES_INIT; otherwise stay.
REQ-023 PLAY: lives would reach 0 this cycle -> OVER; otherwise stay; start ignored.
REQ-024 OVER: score_bcd, combo and lives frozen; start=1 -> PLAY with the same loads as REQ-022.
REQ-025 Each PLAY cycle: N = popcount(accepted hits), M = popcount(accepted misses), 0-LANES each.
REQ-026 Points = N x (2 if combo before update >= COMBO_X2, else 1).
REQ-027 score_bcd SHALL add points as valid BCD with decimal carry, saturating at 999.
REQ-028 If M = 0: combo = combo + N, saturating at 255; if M > 0: combo = 0, even when N > 0 in the same cycle.
REQ-029 lives = lives - M, floored at 0; PLAY -> OVER when the result is 0.
REQ-030 Simultaneous hit and miss in one cycle: points awarded first, then combo cleared and lives reduced.
REQ-031 Latency: an input edge in cycle T updates score_bcd, combo, lives and the pulses visible in cycle T+1.
REQ-032 hit_pulse = (N > 0), miss_pulse = (M > 0); both registered and high for exactly one cycle per accepting cycle.
REQ-033 playing and game_over SHALL be registered decodes of state, never both high.
REQ-034 Edges arriving in the cycle of an IDLE/OVER -> PLAY transition SHALL be ignored.

Reset
REQ-035 With resetn=0 at posedge clk: state IDLE; score_bcd 12'h000, combo 0, lives 0; playing, game_over, hit_pulse, miss_pulse 0.
REQ-036 Reset also clears all lockout counters and registered hit/miss copies, and takes priority over every other input.
REQ-037 Reset asserted mid-game SHALL discard any event pending in that cycle.

Verification
REQ-038 Reset, start pulse, lane 0 hit rises once -> one cycle later score_bcd 12'h001, combo 1, lives 3, hit_pulse high for 1 cycle.
REQ-039 Lane 0 hit toggled at 10-cycle intervals, HOLDOFF=3000 -> only the first edge counts; an edge after 3000 cycles counts.
REQ-040 Combo 7; hit on lanes 0,1 same cycle -> score +2, combo 9; next hit -> score +2.
REQ-041 Score 12'h998; two hits at combo >= 8 -> score_bcd 12'h999, saturated.
REQ-042 Lives 1; hit lane 2 and miss lane 3 same cycle -> score +1, combo 0, lives 0, game_over 1, playing 0; later hits ignored.
REQ-043 In OVER, start=1 -> PLAY with score 0, combo 0, lives 3; hit held high across the transition is not counted.
